// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: drives one external 1-bit ALU slice per clock, LSB first,
// and assembles the WIDTH-bit result plus zero/carry/overflow flags.
module alu_serial_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       ALU_control,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow,
  output logic             slice_src1,
  output logic             slice_src2,
  output logic             slice_less,
  output logic             slice_A_invert,
  output logic             slice_B_invert,
  output logic             slice_cin,
  output logic [1:0]       slice_operation,
  input  logic             slice_result,
  input  logic             slice_cout,
  output logic [1:0]       dbg_state
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-2:0] res_q;
  logic             a_inv_q;
  logic             b_inv_q;
  logic [1:0]       op_q;
  logic             arith_q;
  logic             slt_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             cout_q;
  logic             ovf_q;

  logic             dec_a_inv;
  logic             dec_b_inv;
  logic [1:0]       dec_op;
  logic             dec_cin0;
  logic             dec_arith;
  logic             dec_slt;
  logic             dec_valid;

  always_comb begin
    dec_a_inv = 1'b0;
    dec_b_inv = 1'b0;
    dec_op    = 2'd0;
    dec_cin0  = 1'b0;
    dec_arith = 1'b0;
    dec_slt   = 1'b0;
    dec_valid = 1'b1;
    case (ALU_control)
      4'b0000: dec_op = 2'd0;
      4'b0001: dec_op = 2'd1;
      4'b0010: begin
        dec_op    = 2'd2;
        dec_arith = 1'b1;
      end
      4'b0110: begin
        dec_b_inv = 1'b1;
        dec_op    = 2'd2;
        dec_cin0  = 1'b1;
        dec_arith = 1'b1;
      end
      4'b0111: begin
        dec_b_inv = 1'b1;
        dec_op    = 2'd2;
        dec_cin0  = 1'b1;
        dec_arith = 1'b1;
        dec_slt   = 1'b1;
      end
      4'b1100: begin
        dec_a_inv = 1'b1;
        dec_b_inv = 1'b1;
        dec_op    = 2'd0;
      end
      default: dec_valid = 1'b0;
    endcase
  end

  // The MSB bit is finished in the same cycle it is captured, so the final word and
  // flags are formed from the live slice outputs plus the bits already assembled.
  logic             run;
  logic             ovf_last;
  logic [WIDTH-1:0] assembled;
  logic [WIDTH-1:0] result_d;

  assign run       = (state_q == S_RUN);
  assign ovf_last  = carry_q ^ slice_cout;
  assign assembled = {slice_result, res_q};

  always_comb begin
    result_d = assembled;
    if (!valid_q) begin
      result_d = '0;
    end else if (slt_q) begin
      result_d = {{(WIDTH-1){1'b0}}, slice_result ^ ovf_last};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      a_inv_q  <= 1'b0;
      b_inv_q  <= 1'b0;
      op_q     <= 2'd0;
      arith_q  <= 1'b0;
      slt_q    <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            idx_q   <= '0;
            carry_q <= dec_cin0;
            a_sh_q  <= src1;
            b_sh_q  <= src2;
            res_q   <= '0;
            a_inv_q <= dec_a_inv;
            b_inv_q <= dec_b_inv;
            op_q    <= dec_op;
            arith_q <= dec_arith;
            slt_q   <= dec_slt;
            valid_q <= dec_valid;
          end
        end
        S_RUN: begin
          carry_q <= slice_cout;
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          if (idx_q == LAST_IDX) begin
            state_q  <= S_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            idx_q    <= '0;
            result_q <= result_d;
            zero_q   <= (result_d == '0);
            cout_q   <= arith_q & slice_cout;
            ovf_q    <= arith_q & ovf_last;
          end else begin
            res_q[idx_q] <= slice_result;
            idx_q        <= idx_q + IW'(1);
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Operands shift right, so the current bit is always at position 0.
  assign slice_src1      = run & a_sh_q[0];
  assign slice_src2      = run & b_sh_q[0];
  assign slice_less      = 1'b0;
  assign slice_A_invert  = run & a_inv_q;
  assign slice_B_invert  = run & b_inv_q;
  assign slice_cin       = run & carry_q;
  assign slice_operation = run ? op_q : 2'd0;

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed bench for alu_serial_seq with a behavioural 1-bit ALU slice attached.
`timescale 1ns/1ps
module tb_alu_serial_seq;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [3:0]       ALU_control = 4'd0;
  logic [WIDTH-1:0] src1 = '0;
  logic [WIDTH-1:0] src2 = '0;
  logic             busy, done, zero, cout, overflow;
  logic [WIDTH-1:0] result;
  logic             slice_src1, slice_src2, slice_less, slice_A_invert, slice_B_invert, slice_cin;
  logic [1:0]       slice_operation;
  logic             slice_result, slice_cout;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_serial_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .ALU_control(ALU_control),
    .src1(src1), .src2(src2),
    .busy(busy), .done(done), .result(result), .zero(zero), .cout(cout), .overflow(overflow),
    .slice_src1(slice_src1), .slice_src2(slice_src2), .slice_less(slice_less),
    .slice_A_invert(slice_A_invert), .slice_B_invert(slice_B_invert), .slice_cin(slice_cin),
    .slice_operation(slice_operation),
    .slice_result(slice_result), .slice_cout(slice_cout),
    .dbg_state(dbg_state)
  );

  // Behavioural alu_bottom cell.
  logic sa, sb;
  assign sa = slice_src1 ^ slice_A_invert;
  assign sb = slice_src2 ^ slice_B_invert;
  assign slice_cout = (sa & sb) | (sa & slice_cin) | (sb & slice_cin);
  always_comb begin
    slice_result = 1'b0;
    case (slice_operation)
      2'd0: slice_result = sa & sb;
      2'd1: slice_result = sa | sb;
      2'd2: slice_result = sa ^ sb ^ slice_cin;
      default: slice_result = slice_less;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge while idle; returns at the negedge where done is high.
  task automatic do_op(input string tag, input logic [3:0] ctl, input logic [31:0] a,
                       input logic [31:0] b, input bit hold, output int lat);
    start = 1'b1;
    ALU_control = ctl;
    src1 = a;
    src2 = b;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    check({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
    while (!done && lat < 100) begin
      if (hold) begin
        src1 = $urandom;
        src2 = $urandom;
        ALU_control = 4'($urandom_range(0, 15));
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic op_check(input string tag, input logic [3:0] ctl, input logic [31:0] a,
                          input logic [31:0] b, input bit hold, input logic [31:0] exp_r,
                          input logic exp_z, input logic exp_c, input logic exp_v);
    int lat;
    do_op(tag, ctl, a, b, hold, lat);
    check({tag, "_latency"}, lat, WIDTH + 1);
    check({tag, "_result"}, result, exp_r);
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_z});
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_c});
    check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_v});
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_held"}, result, exp_r);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_flags", {29'd0, zero, cout, overflow}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    op_check("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    op_check("sub_eq", 4'b0110, 32'h0000_0005, 32'h0000_0005, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    op_check("sub_neg", 4'b0110, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    op_check("slt_neg", 4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
    op_check("slt_ovf", 4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    op_check("slt_eq", 4'b0111, 32'h0000_0003, 32'h0000_0003, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    op_check("and", 4'b0000, 32'h0F0F_0000, 32'h00FF_00FF, 1'b0, 32'h000F_0000, 1'b0, 1'b0, 1'b0);
    op_check("or", 4'b0001, 32'h0F0F_0000, 32'h00FF_00FF, 1'b0, 32'h0FFF_00FF, 1'b0, 1'b0, 1'b0);
    op_check("nor", 4'b1100, 32'h0F0F_0000, 32'h00FF_00FF, 1'b0, 32'hF000_FF00, 1'b0, 1'b0, 1'b0);
    op_check("hold_start", 4'b0010, 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_6789, 1'b0, 1'b0, 1'b0);
    // Issued in the first idle cycle after the previous done pulse.
    op_check("b2b", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0);

    // Reset in the middle of a run, between clock edges.
    start = 1'b1;
    ALU_control = 4'b0010;
    src1 = 32'hFFFF_FFFF;
    src2 = 32'h0000_0001;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_flags", {29'd0, zero, cout, overflow}, 32'd0);
    check("mid_rst_drive", {24'd0, slice_src1, slice_src2, slice_less, slice_A_invert,
                            slice_B_invert, slice_cin, slice_operation}, 32'd0);
    check("mid_rst_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    op_check("add_after_rst", 4'b0010, 32'h0000_0002, 32'h0000_0003, 1'b0, 32'h0000_0005, 1'b0, 1'b0, 1'b0);
    op_check("bad_code", 4'b0011, 32'h0000_0005, 32'h0000_0006, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
